// File: rtl/sseg_scan_decoder.sv
// Readback monitor for a multiplexed active-low 7-segment bus: recovers committed BCD codes per digit.
// Optional macro SSEG_ERR_CNT_EN adds an 8-bit saturating ErrCnt output.
module sseg_scan_decoder #(
   parameter int NDIG   = 4,
   parameter int SETTLE = 3,
   parameter int STABLE = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [6:0]        SSeg,
   input  logic [NDIG-1:0]   AN,
   output logic [4*NDIG-1:0] BCD,
   output logic              Valid,
`ifdef SSEG_ERR_CNT_EN
   output logic [7:0]        ErrCnt,
`endif
   output logic              Err
);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

   // Returns {illegal, code}; unknown patterns flag illegal with code 0.
   function automatic logic [4:0] glyph_decode(input logic [6:0] seg);
      case (seg)
         7'b0000001: return {1'b0, 4'd0};
         7'b1001111: return {1'b0, 4'd1};
         7'b0010010: return {1'b0, 4'd2};
         7'b0000110: return {1'b0, 4'd3};
         7'b1001100: return {1'b0, 4'd4};
         7'b0100100: return {1'b0, 4'd5};
         7'b0100000: return {1'b0, 4'd6};
         7'b0001111: return {1'b0, 4'd7};
         7'b0000000: return {1'b0, 4'd8};
         7'b0000100: return {1'b0, 4'd9};
         7'b1111110: return {1'b0, 4'd10};
         7'b1111111: return {1'b0, 4'd11};
         default:    return {1'b1, 4'd0};
      endcase
   endfunction

   function automatic logic an_is_onehot(input logic [NDIG-1:0] an);
      logic [NDIG-1:0] low;
      low = ~an;
      return (low != '0) && ((low & (low - NDIG'(1))) == '0);
   endfunction

   logic [6:0]            sseg_s1_q, sseg_s2_q;
   logic [NDIG-1:0]       an_s1_q, an_s2_q, an_prev_q;
   state_t                state_q, state_d;
   logic [3:0]            cnt_q, cnt_d;
   logic [NDIG-1:0][3:0]  cand_q, cand_d;
   logic [NDIG-1:0][2:0]  match_q, match_d;
   logic [NDIG-1:0][3:0]  bcd_q, bcd_d;
   logic                  valid_q, valid_d;
   logic                  err_q, err_d;
   logic                  an_chg_s, an_onehot_s, capture_s;
   logic [4:0]            glyph_s;

   assign glyph_s     = glyph_decode(sseg_s2_q);
   assign an_chg_s    = (an_s2_q != an_prev_q);
   assign an_onehot_s = an_is_onehot(an_s2_q);

   // Two-flop synchronisers; idle (all-ones) is the cleared state of the bus copies.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sseg_s1_q <= 7'h7F;
         sseg_s2_q <= 7'h7F;
         an_s1_q   <= '1;
         an_s2_q   <= '1;
         an_prev_q <= '1;
      end else begin
         sseg_s1_q <= SSeg;
         sseg_s2_q <= sseg_s1_q;
         an_s1_q   <= AN;
         an_s2_q   <= an_s1_q;
         an_prev_q <= an_s2_q;
      end
   end

   // Settle FSM, capture into candidates, and commit of stable candidates.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      cand_d    = cand_q;
      match_d   = match_q;
      bcd_d     = bcd_q;
      valid_d   = 1'b0;
      err_d     = 1'b0;
      capture_s = 1'b0;

      if (an_chg_s) begin
         state_d = S_WAIT;
         cnt_d   = 4'(SETTLE);
      end else begin
         case (state_q)
            S_IDLE: state_d = S_IDLE;
            S_WAIT: begin
               if (cnt_q != 4'd0) begin
                  cnt_d = cnt_q - 4'd1;
               end else if (an_onehot_s) begin
                  capture_s = 1'b1;
                  state_d   = S_DONE;
               end else if (an_s2_q == '1) begin
                  state_d = S_IDLE;
               end else begin
                  err_d   = 1'b1;
                  state_d = S_IDLE;
               end
            end
            S_DONE:  state_d = S_DONE;
            default: state_d = S_IDLE;
         endcase
      end

      for (int k = 0; k < NDIG; k++) begin
         if ((match_q[k] >= 3'(STABLE)) && (cand_q[k] != bcd_q[k])) begin
            bcd_d[k] = cand_q[k];
            valid_d  = 1'b1;
         end else begin
            bcd_d[k] = bcd_q[k];
         end
      end

      if (capture_s) begin
         if (glyph_s[4]) begin
            err_d = 1'b1;
         end else begin
            err_d = 1'b0;
         end
         for (int k = 0; k < NDIG; k++) begin
            if (!an_s2_q[k]) begin
               if (glyph_s[4]) begin
                  cand_d[k]  = 4'd0;
                  match_d[k] = 3'd0;
               end else if (cand_q[k] == glyph_s[3:0]) begin
                  match_d[k] = (match_q[k] == 3'd7) ? 3'd7 : match_q[k] + 3'd1;
               end else begin
                  cand_d[k]  = glyph_s[3:0];
                  match_d[k] = 3'd1;
               end
            end else begin
               match_d[k] = match_q[k];
            end
         end
      end else begin
         capture_s = 1'b0;
      end
   end

   // Decoder state and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
         cand_q  <= '0;
         match_q <= '0;
         bcd_q   <= {NDIG{4'd11}};
         valid_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         cand_q  <= cand_d;
         match_q <= match_d;
         bcd_q   <= bcd_d;
         valid_q <= valid_d;
         err_q   <= err_d;
      end
   end

   assign BCD   = bcd_q;
   assign Valid = valid_q;
   assign Err   = err_q;

`ifdef SSEG_ERR_CNT_EN
   logic [7:0] err_cnt_q, err_cnt_d;

   // Saturating error counter, advanced alongside the Err pulse.
   always_comb begin
      if (err_d && (err_cnt_q != 8'd255)) begin
         err_cnt_d = err_cnt_q + 8'd1;
      end else begin
         err_cnt_d = err_cnt_q;
      end
   end

   // Error counter register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_cnt_q <= 8'd0;
      end else begin
         err_cnt_q <= err_cnt_d;
      end
   end

   assign ErrCnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_sseg_scan_decoder.sv
// Directed self-checking bench for sseg_scan_decoder (NDIG=4, SETTLE=3, STABLE=2).
module tb_sseg_scan_decoder;
   localparam int NDIG = 4;

   localparam logic [6:0] G1    = 7'b1001111;
   localparam logic [6:0] G2    = 7'b0010010;
   localparam logic [6:0] G3    = 7'b0000110;
   localparam logic [6:0] G4    = 7'b1001100;
   localparam logic [6:0] G5    = 7'b0100100;
   localparam logic [6:0] G8    = 7'b0000000;
   localparam logic [6:0] GDASH = 7'b1111110;
   localparam logic [6:0] GBLK  = 7'b1111111;
   localparam logic [6:0] GILL  = 7'b1111000;

   logic              clk;
   logic              rst_n;
   logic [6:0]        SSeg;
   logic [NDIG-1:0]   AN;
   logic [4*NDIG-1:0] BCD;
   logic              Valid;
   logic              Err;
`ifdef SSEG_ERR_CNT_EN
   logic [7:0]        ErrCnt;
`endif

   int tests_run    = 0;
   int tests_failed = 0;
   int valid_total  = 0;
   int err_total    = 0;
   int v0, e0;

   sseg_scan_decoder #(.NDIG(NDIG), .SETTLE(3), .STABLE(2)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .SSeg   (SSeg),
      .AN     (AN),
      .BCD    (BCD),
      .Valid  (Valid),
`ifdef SSEG_ERR_CNT_EN
      .ErrCnt (ErrCnt),
`endif
      .Err    (Err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (Valid === 1'b1) valid_total <= valid_total + 1;
      if (Err === 1'b1)   err_total   <= err_total + 1;
   end

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic show(input int dig, input logic [6:0] g, input int cyc);
      SSeg = g;
      AN   = ~(NDIG'(1) << dig);
      cycles(cyc);
      AN   = '1;
      cycles(8);
   endtask

   task automatic scan(input logic [6:0] g0, input logic [6:0] g1,
                       input logic [6:0] g2, input logic [6:0] g3);
      show(0, g0, 20);
      show(1, g1, 20);
      show(2, g2, 20);
      show(3, g3, 20);
   endtask

   task automatic test_reset;
      rst_n = 1'b0; AN = '1; SSeg = GBLK;
      cycles(3);
      rst_n = 1'b1;
      v0 = valid_total; e0 = err_total;
      cycles(30);
      tests_run++;
      if (BCD !== 16'hBBBB) begin tests_failed++; $display("FAIL reset_bcd got %h want %h", BCD, 16'hBBBB); end
      tests_run++;
      if (valid_total - v0 !== 0) begin tests_failed++; $display("FAIL reset_valid got %0d want 0", valid_total - v0); end
      tests_run++;
      if (err_total - e0 !== 0) begin tests_failed++; $display("FAIL reset_err got %0d want 0", err_total - e0); end
   endtask

   task automatic test_scan;
      v0 = valid_total;
      scan(G1, G2, G3, G4);
      tests_run++;
      if (BCD !== 16'hBBBB) begin tests_failed++; $display("FAIL scan1_bcd got %h want %h", BCD, 16'hBBBB); end
      tests_run++;
      if (valid_total - v0 !== 0) begin tests_failed++; $display("FAIL scan1_valid got %0d want 0", valid_total - v0); end
      v0 = valid_total;
      scan(G1, G2, G3, G4);
      tests_run++;
      if (BCD !== 16'h4321) begin tests_failed++; $display("FAIL scan2_bcd got %h want %h", BCD, 16'h4321); end
      tests_run++;
      if (valid_total - v0 !== 4) begin tests_failed++; $display("FAIL scan2_valid got %0d want 4", valid_total - v0); end
      v0 = valid_total;
      scan(G1, G2, G3, G4);
      tests_run++;
      if (BCD !== 16'h4321) begin tests_failed++; $display("FAIL scan3_bcd got %h want %h", BCD, 16'h4321); end
      tests_run++;
      if (valid_total - v0 !== 0) begin tests_failed++; $display("FAIL scan3_valid got %0d want 0", valid_total - v0); end
   endtask

   task automatic test_dash_blank;
      v0 = valid_total;
      show(2, GDASH, 20);
      show(2, GDASH, 20);
      tests_run++;
      if (BCD !== 16'h4A21) begin tests_failed++; $display("FAIL dash_bcd got %h want %h", BCD, 16'h4A21); end
      tests_run++;
      if (valid_total - v0 !== 1) begin tests_failed++; $display("FAIL dash_valid got %0d want 1", valid_total - v0); end
      v0 = valid_total;
      show(2, GBLK, 20);
      show(2, GBLK, 20);
      tests_run++;
      if (BCD !== 16'h4B21) begin tests_failed++; $display("FAIL blank_bcd got %h want %h", BCD, 16'h4B21); end
      tests_run++;
      if (valid_total - v0 !== 1) begin tests_failed++; $display("FAIL blank_valid got %0d want 1", valid_total - v0); end
   endtask

   task automatic test_illegal_glyph;
      v0 = valid_total; e0 = err_total;
      show(1, GILL, 20);
      tests_run++;
      if (err_total - e0 !== 1) begin tests_failed++; $display("FAIL illegal_err got %0d want 1", err_total - e0); end
      tests_run++;
      if (BCD !== 16'h4B21) begin tests_failed++; $display("FAIL illegal_bcd got %h want %h", BCD, 16'h4B21); end
      tests_run++;
      if (valid_total - v0 !== 0) begin tests_failed++; $display("FAIL illegal_valid got %0d want 0", valid_total - v0); end
`ifdef SSEG_ERR_CNT_EN
      tests_run++;
      if (ErrCnt !== 8'd1) begin tests_failed++; $display("FAIL errcnt got %0d want 1", ErrCnt); end
`endif
   endtask

   task automatic test_bad_an;
      v0 = valid_total; e0 = err_total;
      SSeg = G8;
      AN   = 4'b1100;
      cycles(20);
      AN   = '1;
      cycles(8);
      tests_run++;
      if (err_total - e0 !== 1) begin tests_failed++; $display("FAIL multihot_err got %0d want 1", err_total - e0); end
      tests_run++;
      if (valid_total - v0 !== 0) begin tests_failed++; $display("FAIL multihot_valid got %0d want 0", valid_total - v0); end
      tests_run++;
      if (BCD !== 16'h4B21) begin tests_failed++; $display("FAIL multihot_bcd got %h want %h", BCD, 16'h4B21); end
      // Short activations must not capture: one real strobe of 8 afterwards must not commit.
      v0 = valid_total; e0 = err_total;
      for (int i = 0; i < 8; i++) begin
         AN = (i % 2 == 0) ? 4'b1110 : 4'b1111;
         cycles(2);
      end
      AN = '1;
      cycles(10);
      show(0, G8, 20);
      tests_run++;
      if (err_total - e0 !== 0) begin tests_failed++; $display("FAIL glitch_err got %0d want 0", err_total - e0); end
      tests_run++;
      if (valid_total - v0 !== 0) begin tests_failed++; $display("FAIL glitch_valid got %0d want 0", valid_total - v0); end
      tests_run++;
      if (BCD !== 16'h4B21) begin tests_failed++; $display("FAIL glitch_bcd got %h want %h", BCD, 16'h4B21); end
   endtask

   task automatic test_reset_mid;
      show(0, G5, 20);
      SSeg = G5;
      AN   = 4'b1110;
      cycles(4);
      rst_n = 1'b0;
      #1;
      tests_run++;
      if (BCD !== 16'hBBBB) begin tests_failed++; $display("FAIL midrst_bcd got %h want %h", BCD, 16'hBBBB); end
      tests_run++;
      if (Valid !== 1'b0 || Err !== 1'b0) begin tests_failed++; $display("FAIL midrst_flags got %b%b want 00", Valid, Err); end
      AN = '1;
      cycles(3);
      rst_n = 1'b1;
      v0 = valid_total; e0 = err_total;
      cycles(10);
      tests_run++;
      if ((valid_total - v0) + (err_total - e0) !== 0) begin
         tests_failed++; $display("FAIL release_pulses got %0d want 0", (valid_total - v0) + (err_total - e0));
      end
      show(0, G5, 20);
      tests_run++;
      if (BCD !== 16'hBBBB) begin tests_failed++; $display("FAIL resume1_bcd got %h want %h", BCD, 16'hBBBB); end
      v0 = valid_total;
      show(0, G5, 20);
      tests_run++;
      if (BCD !== 16'hBBB5) begin tests_failed++; $display("FAIL resume2_bcd got %h want %h", BCD, 16'hBBB5); end
      tests_run++;
      if (valid_total - v0 !== 1) begin tests_failed++; $display("FAIL resume2_valid got %0d want 1", valid_total - v0); end
   endtask

   initial begin
      rst_n = 1'b0;
      AN    = '1;
      SSeg  = GBLK;
      test_reset();
      test_scan();
      test_dash_blank();
      test_illegal_glyph();
      test_bad_an();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
